// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder for the SynFifo write port.
// Words arrive on a valid/ready handshake and are shifted out MSB-first, one bit
// for each cycle the FIFO can take it. An even-parity bit can optionally follow
// each word. A new word can be accepted while the last bit of the previous word
// is being written, so streaming has no gaps.
module bit_serializer #(
  parameter int DATA_W    = 8,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] byteIn,
  input  logic              byteValid,
  output logic              byteReady,
  input  logic              bFull,
  output logic              wEN,
  output logic              dIn,
  output logic              busy,
  output logic              frameDone
);

  localparam int CW = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              par_q, par_d;
  logic              fdone_q, fdone_d;

  logic writing;
  logic last_bit;
  logic accept;
  logic ser_bit;

  // Handshake and write-port decode; RESET gates outputs in the reset cycle itself
  always_comb begin
    writing  = !RESET && (state_q == SHIFT || state_q == PARITY) && !bFull;
    last_bit = writing &&
               ((state_q == SHIFT && cnt_q == CW'(DATA_W - 1) && !PARITY_EN) ||
                state_q == PARITY);
    accept   = byteValid && !RESET && (state_q == IDLE || last_bit);
    ser_bit  = 1'b0;
    if (!RESET) begin
      if (state_q == SHIFT) begin
        ser_bit = shreg_q[DATA_W-1];
      end else if (state_q == PARITY) begin
        ser_bit = par_q;
      end
    end
  end

  assign byteReady = !RESET && (state_q == IDLE || last_bit);
  assign wEN       = writing;
  assign dIn       = ser_bit;
  assign busy      = !RESET && (state_q != IDLE);
  assign frameDone = fdone_q && !RESET;

  // Next-state: shift and count advance only on cycles that actually write
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    fdone_d = last_bit;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          shreg_d = byteIn;
          cnt_d   = '0;
          par_d   = ^byteIn;
        end
      end
      SHIFT: begin
        if (writing) begin
          if (cnt_q == CW'(DATA_W - 1)) begin
            if (PARITY_EN) begin
              state_d = PARITY;
            end else if (accept) begin
              state_d = SHIFT;
              shreg_d = byteIn;
              cnt_d   = '0;
              par_d   = ^byteIn;
            end else begin
              state_d = IDLE;
            end
          end else begin
            shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (writing) begin
          if (accept) begin
            state_d = SHIFT;
            shreg_d = byteIn;
            cnt_d   = '0;
            par_d   = ^byteIn;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      fdone_q <= fdone_d;
    end
  end

endmodule
